// File: rtl/unary_stream_decoder.sv
// Counts ones in a serial unary bitstream of INPUT_WIDTH bits and returns the binary value.
// Optional macro UNARY_DECODE_SKID_EN adds an output register so back-to-back streams need no gap.
module unary_stream_decoder #(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_bit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [COUNT_WIDTH-1:0] lower_bound,
  output logic [COUNT_WIDTH-1:0] upper_bound,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun
);

  // state   | meaning
  // COLLECT | accepting stream bits, in_ready=1
  // HOLD    | completed value parked in the collector, in_ready=0
  typedef enum logic {COLLECT, HOLD} state_e;

  localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE  = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] ones_q, ones_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   overrun_q, overrun_d;

  logic                   accept;
  logic                   out_take;
  logic [COUNT_WIDTH-1:0] ones_inc;

  assign in_ready     = (state_q == COLLECT);
  assign accept       = in_valid && in_ready;
  assign out_take     = result_valid_q && result_ready;
  assign ones_inc     = ones_q + (in_bit ? ONE : '0);

  // In HOLD count_q==FULL and ones_q is the completed value, so both bounds equal it.
  assign lower_bound  = ones_q;
  assign upper_bound  = FULL - count_q + ones_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= COLLECT;
      ones_q         <= '0;
      count_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ones_q         <= ones_d;
      count_q        <= count_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ones_d         = ones_q;
    count_d        = count_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q | (in_valid & ~in_ready);

`ifdef UNARY_DECODE_SKID_EN
    if (out_take) result_valid_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (count_q == LAST) begin
            if (!result_valid_q || out_take) begin
              result_d       = ones_inc;
              result_valid_d = 1'b1;
              ones_d         = '0;
              count_d        = '0;
            end else begin
              ones_d  = ones_inc;
              count_d = FULL;
              state_d = HOLD;
            end
          end else begin
            ones_d  = ones_inc;
            count_d = count_q + ONE;
          end
        end
      end
      HOLD: begin
        if (out_take) begin
          result_d       = ones_q;
          result_valid_d = 1'b1;
          ones_d         = '0;
          count_d        = '0;
          state_d        = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
`else
    case (state_q)
      COLLECT: begin
        if (accept) begin
          ones_d  = ones_inc;
          count_d = count_q + ONE;
          if (count_q == LAST) begin
            result_d       = ones_inc;
            result_valid_d = 1'b1;
            count_d        = FULL;
            state_d        = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_take) begin
          result_valid_d = 1'b0;
          ones_d         = '0;
          count_d        = '0;
          state_d        = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
`endif
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Scoreboard bench for unary_stream_decoder at INPUT_WIDTH=8.
module tb_unary_stream_decoder;

`ifdef UNARY_DECODE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] lower_bound;
  logic [3:0] upper_bound;
  logic [3:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  unary_stream_decoder #(.INPUT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .lower_bound(lower_bound), .upper_bound(upper_bound), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input logic [7:0] bits);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[i];
      tick();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Pop one expected value for every output handshake.
  always @(negedge clk) begin
    if (reset && result_valid && result_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", int'(result), -1);
      else chk("sb_result", int'(result), exp_q.pop_front());
    end
  end

  initial begin
    logic [7:0] s1;
    reset        = 1'b0;
    in_bit       = 1'b0;
    in_valid     = 1'b0;
    result_ready = 1'b1;
    #12;
    chk("rst_lower", int'(lower_bound), 0);
    chk("rst_upper", int'(upper_bound), 8);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Stream 1,0,1,1,0,0,1,0 (LSB first) with bound sampling
    s1 = 8'b0100_1101;
    exp_q.push_back(4);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = s1[i];
      tick();
      if (i == 0) begin
        chk("bnd1_lower", int'(lower_bound), 1);
        chk("bnd1_upper", int'(upper_bound), 8);
      end
      if (i == 2) begin
        chk("bnd3_lower", int'(lower_bound), 2);
        chk("bnd3_upper", int'(upper_bound), 7);
      end
    end
    in_valid = 1'b0;
    chk("bnd8_lower", int'(lower_bound), SKID ? 0 : 4);
    chk("bnd8_upper", int'(upper_bound), SKID ? 8 : 4);
    chk("s1_valid_hi", int'(result_valid), 1);
    chk("s1_result", int'(result), 4);
    chk("s1_ready_hold", int'(in_ready), SKID ? 1 : 0);
    tick();
    chk("s1_valid_lo", int'(result_valid), 0);
    chk("s1_ready_back", int'(in_ready), 1);
    chk("s1_bnd_clr", int'(upper_bound), 8);

`ifndef UNARY_DECODE_SKID_EN
    // Backpressure with an overrun pulse while holding
    result_ready = 1'b0;
    exp_q.push_back(8);
    send_stream(8'hFF);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", int'(result_valid), 1);
      chk("bp_result", int'(result), 8);
      chk("bp_ready", int'(in_ready), 0);
      in_valid = (k == 2);
      in_bit   = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_overrun", int'(overrun), 1);
    chk("bp_lower", int'(lower_bound), 8);
    chk("bp_upper", int'(upper_bound), 8);
    result_ready = 1'b1;
    tick();
    chk("bp_valid_lo", int'(result_valid), 0);
    chk("bp_ready_back", int'(in_ready), 1);
    chk("bp_overrun_sticky", int'(overrun), 1);
`endif

    // Gapped zeros
    exp_q.push_back(0);
    for (int i = 0; i < 15; i++) begin
      in_valid = (i % 2 == 0);
      in_bit   = 1'b0;
      tick();
      if (i < 14) chk("gap_upper", int'(upper_bound), 8 - (i / 2 + 1));
    end
    in_valid = 1'b0;
    chk("gap_valid", int'(result_valid), 1);
    chk("gap_result", int'(result), 0);
    tick();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = (i != 2);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_lower", int'(lower_bound), 4);
    reset = 1'b0;
    #1;
    chk("arst_lower", int'(lower_bound), 0);
    chk("arst_upper", int'(upper_bound), 8);
    chk("arst_result", int'(result), 0);
    chk("arst_valid", int'(result_valid), 0);
    chk("arst_overrun", int'(overrun), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    exp_q.push_back(3);
    send_stream(8'b0000_0111);
    chk("post_rst_result", int'(result), 3);
    tick();
    tick();

`ifdef UNARY_DECODE_SKID_EN
    // Back-to-back streams 6 then 2 with no gap
    exp_q.push_back(6);
    exp_q.push_back(2);
    s1 = 8'b0011_1111;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_bit   = (i < 8) ? s1[i] : (i < 10);
      tick();
      chk("b2b_ready", int'(in_ready), 1);
      chk("b2b_valid", int'(result_valid), (i == 7 || i == 15) ? 1 : 0);
    end
    in_valid = 1'b0;
    chk("b2b_overrun", int'(overrun), 0);
    tick();
    tick();
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
